// File: rtl/ffo32s_decode.sv
//----------------------------------------------------------------------------
// Module      : ffo32s_decode
// Description : Sequential position-to-vector decoder (inverse of the
//               find-first-one encoder), MSB-first bit numbering, with a
//               start/ready handshake. Optional thermometer output mode is
//               enabled by defining FFO_DECODE_THERMO_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ffo32s_decode #(
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [PW-1:0]   p,
    output logic [0:WIDTH-1] b,
    output logic            ready
`ifdef FFO_DECODE_THERMO_EN
    ,
    input  logic            mode
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam logic [PW-1:0] c_last = PW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PW-1:0]      r_count;
    logic [PW-1:0]      r_preg;
    logic [0:WIDTH-1]   r_sr;
    logic [0:WIDTH-1]   r_b;
    logic               w_hit;
    logic               w_done;
    logic               w_fill;
    logic               w_accept;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_hit    = (r_count == r_preg);
    // The WIDTH-1 bound also ends runs whose position cannot be reached.
    assign w_done   = w_hit || (r_count == c_last);

`ifdef FFO_DECODE_THERMO_EN
    logic r_mode;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_mode <= mode;
        end
    end

    assign w_fill = r_mode;
`else
    assign w_fill = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_preg  <= '0;
            r_sr    <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_preg <= p;
                    end
                end
                S_LOAD: begin
                    r_sr    <= {1'b1, {(WIDTH-1){1'b0}}};
                    r_count <= '0;
                end
                S_SHIFT: begin
                    if (w_done) begin
                        r_b <= w_hit ? r_sr : '0;
                    end else begin
                        r_sr    <= {w_fill, r_sr[0:WIDTH-2]};
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign b     = r_b;
    assign ready = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ffo32s_decode.sv
//----------------------------------------------------------------------------
// Module      : tb_ffo32s_decode
// Description : Directed self-checking bench for ffo32s_decode.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_ffo32s_decode;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  p;
    logic [0:31] b;
    logic        ready;
    logic        mode;

    int n_checks;
    int n_errors;
    logic [31:0] exp_prev;

    ffo32s_decode #(.WIDTH(32), .PW(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .p     (p),
        .b     (b),
        .ready (ready)
`ifdef FFO_DECODE_THERMO_EN
        ,
        .mode  (mode)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Find-first-one encoder model, index 0 = leftmost bit.
    function automatic logic [5:0] ffo(input logic [0:31] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return 6'(i);
        end
        return 6'd32;
    endfunction

    // Entered with ready high, #1 after a rising edge; returns the same way.
    task automatic run_op(input logic [4:0] pp, input logic md,
                          input logic [31:0] exp_b, input int pulse_at,
                          input bit loopback);
        int n;
        start = 1'b1;
        p     = pp;
        mode  = md;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        check("ready_low_after_start", 32'(ready), 32'd0);
        while (!ready && n < 100) begin
            check("b_hold", b, exp_prev);
            start = (n == pulse_at);
            p     = ~pp;
            @(posedge clock); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'(pp) + 32'd3);
        check("b_result", b, exp_b);
        if (loopback) check("loopback_pos", 32'(ffo(b)), 32'(pp));
        exp_prev = exp_b;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_prev = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        p     = 5'd0;
        mode  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_b", b, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(5'd0,  1'b0, 32'h8000_0000, -1, 1'b1);
        run_op(5'd31, 1'b0, 32'h0000_0001, -1, 1'b1);
        run_op(5'd5,  1'b0, 32'h0400_0000, -1, 1'b0);
        // Back-to-back: start on the very cycle ready rose.
        run_op(5'd9,  1'b0, 32'h0040_0000, -1, 1'b0);

        for (int i = 0; i < 32; i++) begin
            run_op(5'(i), 1'b0, 32'h8000_0000 >> i, (i % 2 == 1) ? 2 : -1, 1'b1);
        end

        // Reset in SHIFT, four cycles after acceptance.
        start = 1'b1;
        p     = 5'd20;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("pre_reset_busy", 32'(ready), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_b", b, 32'h0);
        exp_prev = 32'h0;
        run_op(5'd2, 1'b0, 32'h2000_0000, -1, 1'b1);

`ifdef FFO_DECODE_THERMO_EN
        run_op(5'd3,  1'b1, 32'hF000_0000, -1, 1'b0);
        run_op(5'd31, 1'b1, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(5'd3,  1'b0, 32'h1000_0000, -1, 1'b1);
        run_op(5'd0,  1'b1, 32'h8000_0000, -1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
